// File: rtl/idma_channel_arbiter_if.sv
// rtl/idma_channel_arbiter_if.sv - channel-side and backend-side signals of the iDMA channel arbiter
interface idma_channel_arbiter_if #(
    parameter int  NumChannels = 4,
    parameter type burst_req_t = logic
);
    burst_req_t             ch_req_i [NumChannels];
    logic [NumChannels-1:0] ch_valid_i;
    logic [NumChannels-1:0] ch_ready_o;
    logic [NumChannels-1:0] ch_done_o;
    logic [NumChannels-1:0] ch_busy_o;
    burst_req_t             burst_req_o;
    logic                   valid_o;
    logic                   ready_i;
    logic                   trans_complete_i;
    logic                   idle_o;
    logic                   err_o;

    modport slave (
        input  ch_req_i, ch_valid_i, ready_i, trans_complete_i,
        output ch_ready_o, ch_done_o, ch_busy_o, burst_req_o, valid_o, idle_o, err_o
    );

    modport master (
        output ch_req_i, ch_valid_i, ready_i, trans_complete_i,
        input  ch_ready_o, ch_done_o, ch_busy_o, burst_req_o, valid_o, idle_o, err_o
    );
endinterface

// File: rtl/idma_channel_arbiter.sv
// rtl/idma_channel_arbiter.sv - round-robin sharing of one iDMA backend with in-order completion routing
module idma_channel_arbiter #(
    parameter int  NumChannels    = 4,
    parameter int  MaxOutstanding = 8,
    parameter type burst_req_t    = logic
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    idma_channel_arbiter_if.slave bus
);
    localparam int IdxW = $clog2(NumChannels);
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW = $clog2(MaxOutstanding + 1);

    logic [IdxW-1:0] r_rr_ptr;
    logic [IdxW-1:0] r_lock_idx;
    logic            r_locked;
    logic [IdxW-1:0] r_fifo [MaxOutstanding];
    logic [PtrW-1:0] r_wptr;
    logic [PtrW-1:0] r_rptr;
    logic [CntW-1:0] r_count;
    logic [CntW-1:0] r_ch_cnt [NumChannels];

    logic            w_grant_vld;
    logic [IdxW-1:0] w_grant_idx;
    logic [IdxW-1:0] w_cand;
    int              w_scan;
    logic            w_full;
    logic            w_empty;
    logic            w_valid;
    logic            w_handshake;
    logic            w_pop;
    logic [IdxW-1:0] w_head;
    burst_req_t      w_req;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    // Scan offsets from the top down so the smallest offset from rr_ptr is written last and wins.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_scan      = 0;
        w_cand      = '0;
        if (r_locked) begin
            w_grant_vld = 1'b1;
            w_grant_idx = r_lock_idx;
        end else begin
            for (int k = NumChannels - 1; k >= 0; k--) begin
                w_scan = (int'(r_rr_ptr) + k) % NumChannels;
                w_cand = IdxW'(w_scan);
                if (bus.ch_valid_i[w_cand]) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = w_cand;
                end
            end
        end
    end

    assign w_full      = (r_count == CntW'(MaxOutstanding));
    assign w_empty     = (r_count == '0);
    assign w_valid     = rst_ni & w_grant_vld & ~w_full;
    assign w_handshake = w_valid & bus.ready_i;
    assign w_head      = r_fifo[r_rptr];
    assign w_pop       = rst_ni & bus.trans_complete_i & ~w_empty;

    assign bus.valid_o = w_valid;
    assign bus.err_o   = rst_ni & bus.trans_complete_i & w_empty;
    assign bus.idle_o  = w_empty;

    always_comb begin
        bus.ch_ready_o = '0;
        bus.ch_done_o  = '0;
        w_req          = '0;
        if (w_handshake) bus.ch_ready_o[w_grant_idx] = 1'b1;
        if (w_pop)       bus.ch_done_o[w_head]       = 1'b1;
        if (w_grant_vld) w_req = bus.ch_req_i[w_grant_idx];
        bus.burst_req_o = w_req;
    end

    for (genvar g = 0; g < NumChannels; g++) begin : g_busy
        assign bus.ch_busy_o[g] = (r_ch_cnt[g] != '0);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rr_ptr   <= '0;
            r_locked   <= 1'b0;
            r_lock_idx <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            for (int i = 0; i < NumChannels; i++) r_ch_cnt[i] <= '0;
        end else begin
            if (w_handshake) begin
                r_fifo[r_wptr] <= w_grant_idx;
                r_wptr         <= ptr_inc(r_wptr);
                r_rr_ptr       <= (w_grant_idx == IdxW'(NumChannels - 1)) ? '0 : w_grant_idx + 1'b1;
                r_locked       <= 1'b0;
            end else if (w_valid) begin
                // Backend stalled: freeze this grant so later requests cannot preempt it.
                r_locked   <= 1'b1;
                r_lock_idx <= w_grant_idx;
            end
            if (w_pop) r_rptr <= ptr_inc(r_rptr);
            if (w_handshake && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_handshake) r_count <= r_count - 1'b1;
            for (int i = 0; i < NumChannels; i++) begin
                if (bus.ch_ready_o[i] && !bus.ch_done_o[i])      r_ch_cnt[i] <= r_ch_cnt[i] + 1'b1;
                else if (bus.ch_done_o[i] && !bus.ch_ready_o[i]) r_ch_cnt[i] <= r_ch_cnt[i] - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_idma_channel_arbiter.sv
// tb/tb_idma_channel_arbiter.sv - directed and randomized checks of idma_channel_arbiter against a queue model
module tb_idma_channel_arbiter;
    localparam int N = 4;
    localparam int M = 8;
    typedef logic [15:0] req_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    idma_channel_arbiter_if #(.NumChannels(N), .burst_req_t(req_t)) bus ();

    idma_channel_arbiter #(
        .NumChannels   (N),
        .MaxOutstanding(M),
        .burst_req_t   (req_t)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference state: issue-ordered queue of channel ids, rotating pointer, held grant.
    int       q[$];
    int       rr      = 0;
    bit       locked  = 1'b0;
    int       lock_g  = 0;
    logic [N-1:0] m_acc = '0;

    always @(negedge clk) begin : model_compare
        int           g;
        bit           hg, full, e_valid, hs, pop, err;
        logic [N-1:0] e_rdy, e_done, e_busy;
        req_t         e_req;
        full = (q.size() == M);
        hg   = 1'b0;
        g    = 0;
        if (locked) begin
            hg = 1'b1;
            g  = lock_g;
        end else begin
            for (int k = 0; k < N; k++)
                if (!hg && bus.ch_valid_i[(rr + k) % N] === 1'b1) begin
                    hg = 1'b1;
                    g  = (rr + k) % N;
                end
        end
        e_valid = rst_n && hg && !full;
        hs      = e_valid && bus.ready_i;
        e_rdy   = '0;
        if (hs) e_rdy[g] = 1'b1;
        pop    = rst_n && bus.trans_complete_i && q.size() > 0;
        err    = rst_n && bus.trans_complete_i && q.size() == 0;
        e_done = '0;
        if (pop) e_done[q[0]] = 1'b1;
        e_busy = '0;
        foreach (q[j]) e_busy[q[j]] = 1'b1;
        e_req = hg ? bus.ch_req_i[g] : '0;

        chk("valid_o", 32'(bus.valid_o), 32'(e_valid));
        chk("ch_ready_o", 32'(bus.ch_ready_o), 32'(e_rdy));
        chk("burst_req_o", 32'(bus.burst_req_o), 32'(e_req));
        chk("ch_done_o", 32'(bus.ch_done_o), 32'(e_done));
        chk("err_o", 32'(bus.err_o), 32'(err));
        chk("idle_o", 32'(bus.idle_o), 32'(q.size() == 0));
        chk("ch_busy_o", 32'(bus.ch_busy_o), 32'(e_busy));
        m_acc = e_rdy;

        if (!rst_n) begin
            q.delete();
            rr     = 0;
            locked = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (hs) begin
                q.push_back(g);
                rr     = (g + 1) % N;
                locked = 1'b0;
            end else if (e_valid) begin
                locked = 1'b1;
                lock_g = g;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ch_valid_i       = '0;
        bus.ready_i          = 1'b0;
        bus.trans_complete_i = 1'b0;
        for (int i = 0; i < N; i++) bus.ch_req_i[i] = '0;
    endtask

    task automatic do_reset();
        cyc();
        rst_n = 1'b0;
        idle_inputs();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        int order [6];
        order = '{0, 1, 2, 3, 0, 1};
        idle_inputs();
        do_reset();
        @(negedge clk);
        chk("rst_idle", 32'(bus.idle_o), 32'd1);
        chk("rst_busy", 32'(bus.ch_busy_o), 32'd0);

        // Single request from channel 1
        cyc();
        bus.ch_valid_i  = 4'b0010;
        bus.ch_req_i[1] = 16'hA1A1;
        bus.ready_i     = 1'b1;
        @(negedge clk);
        chk("t1_valid", 32'(bus.valid_o), 32'd1);
        chk("t1_req", 32'(bus.burst_req_o), 32'hA1A1);
        chk("t1_ready", 32'(bus.ch_ready_o), 32'b0010);
        cyc();
        bus.ch_valid_i = '0;
        bus.ready_i    = 1'b0;
        @(negedge clk);
        chk("t1_busy", 32'(bus.ch_busy_o), 32'b0010);
        chk("t1_idle", 32'(bus.idle_o), 32'd0);
        cyc();
        bus.trans_complete_i = 1'b1;
        @(negedge clk);
        chk("t1_done", 32'(bus.ch_done_o), 32'b0010);
        cyc();
        bus.trans_complete_i = 1'b0;
        @(negedge clk);
        chk("t1_idle_after", 32'(bus.idle_o), 32'd1);

        // Fairness with all channels requesting
        do_reset();
        bus.ch_valid_i = 4'b1111;
        for (int i = 0; i < N; i++) bus.ch_req_i[i] = 16'h2000 + 16'(i);
        bus.ready_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("t2_order", 32'(bus.ch_ready_o), 32'(1) << order[c]);
            cyc();
        end

        // Held grant while the backend stalls
        do_reset();
        bus.ch_valid_i  = 4'b0100;
        bus.ch_req_i[2] = 16'hC2C2;
        @(negedge clk);
        chk("t3_req", 32'(bus.burst_req_o), 32'hC2C2);
        cyc();
        bus.ch_valid_i  = 4'b0101;
        bus.ch_req_i[0] = 16'h0C0C;
        @(negedge clk);
        chk("t3_hold1", 32'(bus.burst_req_o), 32'hC2C2);
        cyc();
        @(negedge clk);
        chk("t3_hold2", 32'(bus.burst_req_o), 32'hC2C2);
        cyc();
        bus.ready_i = 1'b1;
        @(negedge clk);
        chk("t3_accept", 32'(bus.ch_ready_o), 32'b0100);
        cyc();
        bus.ch_valid_i = 4'b0001;
        @(negedge clk);
        chk("t3_next", 32'(bus.ch_ready_o), 32'b0001);

        // FIFO full blocks issue until a completion has been registered
        do_reset();
        bus.ch_valid_i = 4'b1111;
        bus.ready_i    = 1'b1;
        for (int c = 0; c < M; c++) begin
            @(negedge clk);
            cyc();
        end
        @(negedge clk);
        chk("t4_full", 32'(bus.valid_o), 32'd0);
        cyc();
        bus.trans_complete_i = 1'b1;
        @(negedge clk);
        chk("t4_pop_same", 32'(bus.valid_o), 32'd0);
        chk("t4_done", 32'(bus.ch_done_o), 32'b0001);
        cyc();
        bus.trans_complete_i = 1'b0;
        @(negedge clk);
        chk("t4_unblock", 32'(bus.valid_o), 32'd1);
        chk("t4_grant", 32'(bus.ch_ready_o), 32'b0001);

        // Completion with nothing outstanding
        do_reset();
        bus.trans_complete_i = 1'b1;
        @(negedge clk);
        chk("t5_err", 32'(bus.err_o), 32'd1);
        chk("t5_done", 32'(bus.ch_done_o), 32'd0);
        chk("t5_idle", 32'(bus.idle_o), 32'd1);
        cyc();
        bus.trans_complete_i = 1'b0;
        @(negedge clk);
        chk("t5_err_clr", 32'(bus.err_o), 32'd0);

        // Reset with transfers outstanding
        do_reset();
        bus.ready_i    = 1'b1;
        bus.ch_valid_i = 4'b0001;
        @(negedge clk);
        cyc();
        bus.ch_valid_i = 4'b0010;
        @(negedge clk);
        cyc();
        bus.ch_valid_i = 4'b0001;
        @(negedge clk);
        cyc();
        bus.ch_valid_i = '0;
        bus.ready_i    = 1'b0;
        @(negedge clk);
        chk("t6_busy", 32'(bus.ch_busy_o), 32'b0011);
        cyc();
        rst_n          = 1'b0;
        bus.ch_valid_i = 4'b1111;
        bus.ready_i    = 1'b1;
        @(negedge clk);
        chk("t6_rst_valid", 32'(bus.valid_o), 32'd0);
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_idle", 32'(bus.idle_o), 32'd1);
        chk("t6_busy0", 32'(bus.ch_busy_o), 32'd0);
        chk("t6_first", 32'(bus.ch_ready_o), 32'b0001);

        // Randomized traffic: requesters hold until accepted
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst_n                = ($urandom_range(0, 199) != 0);
            bus.ready_i          = ($urandom_range(0, 99) < 60);
            bus.trans_complete_i = ($urandom_range(0, 99) < ((c < 1500) ? 15 : 45));
            for (int i = 0; i < N; i++) begin
                if (!bus.ch_valid_i[i] || m_acc[i]) begin
                    bus.ch_valid_i[i] = ($urandom_range(0, 99) < 40);
                    bus.ch_req_i[i]   = req_t'($urandom);
                end
            end
            cyc();
        end
        rst_n = 1'b1;
        idle_inputs();
        cyc();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
